// File: rtl/ifu_fetch_ctrl_pkg.sv
// ifu_fetch_ctrl_pkg: shared IFU fetch state encoding and PC constants
package ifu_fetch_ctrl_pkg;
  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } fetch_state_t;
  localparam logic [31:0] RESET_PC_DEF = 32'h8000_0000;
  localparam logic [31:0] PC_INC       = 32'd4;
endpackage

// File: rtl/ifu_fetch_ctrl.sv
// ifu_fetch_ctrl: single-outstanding instruction fetch FSM with redirect and response drop
module ifu_fetch_ctrl
  import ifu_fetch_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
  input  logic        clock,
  input  logic        reset,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_req_addr,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_resp_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_inst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc
);
  fetch_state_t state, state_n;
  logic        drop, drop_n;
  logic [31:0] pc, pc_n;
  logic [31:0] inst_q, inst_n, opc_n;
  logic        in_req, in_wait, in_hold, hs, resp, latch;
  assign in_req        = state == S_REQ;
  assign in_wait       = state == S_WAIT;
  assign in_hold       = state == S_HOLD;
  assign hs            = in_req && mem_req_ready;
  assign resp          = in_wait && mem_resp_valid;
  assign latch         = resp && !drop && !redirect_valid;
  assign mem_req_valid = in_req;
  assign mem_req_addr  = pc;
  assign out_valid     = in_hold;
  assign out_inst      = in_hold ? inst_q : '0;
  always_comb begin
    state_n = state;
    drop_n  = drop;
    pc_n    = redirect_valid ? {redirect_pc[31:2], 2'b00}
            : (in_hold && out_ready) ? pc + PC_INC : pc;
    inst_n  = latch ? mem_resp_data : inst_q;
    opc_n   = latch ? pc : out_pc;
    case (state)
      S_REQ: begin
        state_n = hs ? S_WAIT : S_REQ;
        drop_n  = hs && redirect_valid;
      end
      S_WAIT: begin
        state_n = !mem_resp_valid ? S_WAIT : latch ? S_HOLD : S_REQ;
        drop_n  = mem_resp_valid ? 1'b0 : (drop || redirect_valid);
      end
      S_HOLD: state_n = (redirect_valid || out_ready) ? S_REQ : S_HOLD;
      default: begin
        state_n = S_REQ;
        drop_n  = 1'b0;
      end
    endcase
  end
  // Reset wins over redirect and handshakes; an in-flight response is simply forgotten.
  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= S_REQ;
      drop   <= 1'b0;
      pc     <= RESET_PC;
      inst_q <= '0;
      out_pc <= '0;
    end else begin
      state  <= state_n;
      drop   <= drop_n;
      pc     <= pc_n;
      inst_q <= inst_n;
      out_pc <= opc_n;
    end
  end
endmodule
